wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the register file's single write port (A3/WD3/WE3) between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and written only in cycles the pipeline leaves the port idle. A bounded-age rule forces a pipeline writeback stall so MDU results cannot starve. A 32-bit scoreboard tracks destination registers with outstanding MDU results for the hazard unit.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before forcing a pipeline stall (≥1)

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- wb_we  in  1  pipeline writeback request
- wb_addr  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline write data
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept an MDU result
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- issue_valid  in  1  MDU operation issued; marks destination pending
- issue_addr  in  ADDR_W  destination of issued MDU operation
- rf_we / rf_addr / rf_wd  out  1 / ADDR_W / DATA_W  drive WE3 / A3 / WD3
- pipe_stall  out  1  pipeline must hold its writeback stage this cycle
- pending  out  32  scoreboard: bit r set = MDU result for r not yet written
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Grant, per cycle (combinational from registered state and wb_* inputs):
  - pipe_stall=1: grant FIFO head; wb_we ignored (pipeline re-presents next cycle).
  - else wb_we=1 and wb_addr≠0: grant pipeline.
  - else FIFO non-empty: grant FIFO head.
  - else rf_we=0.
- Writes to $0 never assert rf_we and never consume the port slot.
- FIFO push on mdu_valid && mdu_ready; entries with mdu_addr=0 are accepted but not stored.
- mdu_ready = (fifo_count < FIFO_DEPTH) && !reset; no same-cycle pass-through to the port.
- Pop on FIFO-head grant. Simultaneous push and pop is allowed when not full.
- FSM (state in shared package):
  - IDLE: FIFO empty, age=0.
  - DRAIN: head waiting; age increments each ungranted cycle; age reaching STARVE_LIMIT → FORCE.
  - FORCE: pipe_stall=1; head is written this cycle; age cleared; → DRAIN if more entries remain, else IDLE.
  - Any pop resets age to 0.
- Scoreboard:
  - Bit set at posedge on issue_valid with issue_addr≠0.
  - Bit cleared when a FIFO entry for that register is written to the port.
  - Same-cycle set and clear of the same bit: set wins.
  - Pipeline writes never touch the scoreboard.
  - pending[0] is constant 0.

## Timing
- Pipeline write: zero latency. rf_* follows wb_* in the same cycle; the register file captures it on the following negedge.
- MDU write: at least 1 cycle after acceptance. Worst case STARVE_LIMIT+FIFO_DEPTH cycles for the head entry.
- pending bit changes are visible the cycle after the issue or writing posedge.
- Reset values: rf_we=0, rf_addr=0, rf_wd=0, mdu_ready=0 while reset is high (1 once released), pipe_stall=0, pending=0, fifo_count=0, state=IDLE, age=0.
- Reset mid-operation discards FIFO contents and the scoreboard with no port write.
- FIFO pointers wrap modulo FIFO_DEPTH. Full: mdu_ready=0. Empty: no head grant.

## Structure
- Package wb_arb_pkg holds:
  - DATA_W, ADDR_W defaults
  - typedef wb_entry_t {addr, data}
  - arb_state_t enum {IDLE, DRAIN, FORCE}
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push, pop, full, empty and count; async active-high reset.
- Top level holds grant mux, age counter/FSM and scoreboard.

## Test plan
- Idle pipeline: MDU pushes (r5, 0xDEADBEEF) → next cycle rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; pending[5] clears the following cycle.
- Contention with STARVE_LIMIT=4: wb_we=1 every cycle, one MDU entry queued → rf_* shows pipeline data for 4 cycles, then pipe_stall=1 and the MDU entry is written, then pipe_stall=0.
- Full FIFO: 2 accepted entries with continuous wb_we → mdu_ready=0. A third mdu_valid is held until the first pop, then accepted.
- $0 handling: wb_we=1, wb_addr=0 with a queued entry → rf_we=1 with the FIFO entry. mdu_addr=0 push → no write and fifo_count unchanged. issue_addr=0 → pending stays 0.
- Scoreboard race: issue_valid on r7 in the same cycle the old r7 entry pops → pending[7] stays 1.
- Reset mid-drain: 2 entries queued with pending bits set, reset pulsed → all outputs at reset values, and no rf_we afterwards without new pushes.

Source files
------------

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared types and defaults for the register-file write-port
//             arbiter: data/address widths, the buffered MDU result entry,
//             the arbiter state encoding and a register one-hot helper.
//  Revision : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // One buffered MDU result: destination register and value.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    // One-hot scoreboard mask for a register; $0 never has a bit.
    function automatic logic [31:0] reg_onehot(input logic [ADDR_W-1:0] a);
        reg_onehot = (a == '0) ? 32'd0 : (32'd1 << a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter_if
//  Purpose  : Bundles the pipeline writeback, MDU result, MDU issue and
//             register-file write-port signals of the write-port arbiter.
//  Modports : master - pipeline/MDU/regfile side (drives requests)
//             slave  - arbiter side (drives rf_*, stall, ready, scoreboard)
//  Revision : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int DATA_W     = wb_arb_pkg::DATA_W,
    parameter int ADDR_W     = wb_arb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
);

    // Pipeline writeback request
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // MDU result handshake
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    // MDU issue (marks destination pending)
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    // Register-file write port WE3/A3/WD3
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wd;
    // Status
    logic              pipe_stall;
    logic [31:0]       pending;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output wb_we, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        output issue_valid, issue_addr,
        input  mdu_ready, rf_we, rf_addr, rf_wd,
        input  pipe_stall, pending, fifo_count
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  issue_valid, issue_addr,
        output mdu_ready, rf_we, rf_addr, rf_wd,
        output pipe_stall, pending, fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : Synchronous FIFO of wb_entry_t used to buffer MDU results.
//  Ports    : clk, reset (async, active-high)
//             push_i/push_entry_i - write an entry (ignored when full)
//             pop_i               - drop the head (ignored when empty)
//             head_o              - current head entry
//             full_o/empty_o/count_o - occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares the register file's single write port between the
//             pipeline writeback stage and buffered MDU results. MDU results
//             use idle port cycles; a bounded-age rule stalls the pipeline
//             writeback so the FIFO head cannot starve. A scoreboard flags
//             registers whose MDU result is still outstanding.
//  Ports    : clk, reset (async, active-high)
//             bus (slave) - wb_*, mdu_*, issue_* in;
//                           rf_we/rf_addr/rf_wd, pipe_stall, mdu_ready,
//                           pending, fifo_count out
//  Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W       = wb_arb_pkg::DATA_W,
    parameter int ADDR_W       = wb_arb_pkg::ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic [31:0]      pending_q, pending_d;

    wb_entry_t         w_push_entry;
    wb_entry_t         w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_pipe_req;
    logic              w_force;
    logic              w_push;
    logic              w_grant_fifo;
    logic              w_grant_pipe;
    logic [AGE_W-1:0]  w_age_inc;

    // ------------------------------------------------------------------
    // MDU result buffer
    // ------------------------------------------------------------------
    assign bus.mdu_ready = !w_fifo_full && !reset;
    // $0 results are acknowledged but dropped: they would never be written.
    assign w_push        = bus.mdu_valid && bus.mdu_ready && (bus.mdu_addr != '0);

    assign w_push_entry.addr = bus.mdu_addr;
    assign w_push_entry.data = bus.mdu_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_grant_fifo),
        .head_o       (w_head),
        .full_o       (w_fifo_full),
        .empty_o      (w_fifo_empty),
        .count_o      (w_fifo_count)
    );

    assign w_head_addr     = w_head.addr;
    assign w_head_data     = w_head.data;
    assign bus.fifo_count  = w_fifo_count;

    // ------------------------------------------------------------------
    // Grant: forced head > live pipeline write > waiting head
    // ------------------------------------------------------------------
    assign w_force        = (state_q == FORCE);
    assign bus.pipe_stall = w_force;
    // A $0 pipeline write leaves the slot free for the FIFO.
    assign w_pipe_req     = bus.wb_we && (bus.wb_addr != '0);
    assign w_grant_fifo   = !reset && !w_fifo_empty && (w_force || !w_pipe_req);
    assign w_grant_pipe   = !reset && !w_force && w_pipe_req;

    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_addr = '0;
        bus.rf_wd   = '0;
        if (w_grant_fifo) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = w_head_addr;
            bus.rf_wd   = w_head_data;
        end else if (w_grant_pipe) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = bus.wb_addr;
            bus.rf_wd   = bus.wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Head-age FSM
    // ------------------------------------------------------------------
    assign w_count_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_grant_fifo);
    assign w_age_inc    = age_q + AGE_W'(1);

    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        case (state_q)
            IDLE: begin
                age_d = '0;
                if (w_push) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_grant_fifo) begin
                    age_d   = '0;
                    state_d = (w_count_next != '0) ? DRAIN : IDLE;
                end else begin
                    age_d = w_age_inc;
                    if (w_age_inc >= AGE_W'(STARVE_LIMIT)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                // Head is written this cycle; the next head starts fresh.
                age_d   = '0;
                state_d = (w_count_next != '0) ? DRAIN : IDLE;
            end
            default: begin
                age_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard: set wins over a same-cycle clear of the same register
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (w_grant_fifo) begin
            pending_d = pending_d & ~reg_onehot(w_head_addr);
        end
        if (bus.issue_valid) begin
            pending_d = pending_d | reg_onehot(bus.issue_addr);
        end
        pending_d[0] = 1'b0;
    end

    assign bus.pending = pending_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            age_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            age_q     <= age_d;
            pending_q <= pending_d;
        end
    end

endmodule
`default_nettype wire
